// File: rtl/bin2bcd_seq_ctrl.sv
// bin2bcd_seq_ctrl: sequential double-dabble binary-to-BCD converter, one bit per clock, start/done handshake.
module bin2bcd_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0]       r_state, w_next;
  logic [WIDTH-1:0] r_op;
  logic [BW-1:0]    r_acc, w_corr, w_acc_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf, w_accept, w_last, w_ovf_nxt, w_busy_nxt, w_done_nxt;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign w_corr[4*i+:4] = (r_acc[4*i+:4] >= 4'd5) ? r_acc[4*i+:4] + 4'd3 : r_acc[4*i+:4];
  end
  assign w_acc_sh  = {w_corr[BW-2:0], r_op[WIDTH-1]};
  // a carry out of the top digit means the value no longer fits in DIGITS digits
  assign w_ovf_nxt = r_ovf | w_corr[BW-1];
  assign w_accept  = start && (r_state == IDLE || r_state == DONE);
  assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = w_accept ? SHIFT : w_last ? DONE : (r_state == SHIFT) ? SHIFT : IDLE;
  end
  always_comb begin
    w_busy_nxt = (w_next == SHIFT);
    w_done_nxt = (w_next == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= bin_in;
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= CW'(WIDTH);
      end else if (r_state == SHIFT) begin
        r_op  <= {r_op[WIDTH-2:0], 1'b0};
        r_acc <= w_acc_sh;
        r_ovf <= w_ovf_nxt;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_last) begin
        bcd_out  <= w_acc_sh;
        overflow <= w_ovf_nxt;
      end
      busy <= w_busy_nxt;
      done <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb_bin2bcd_seq_ctrl: drives three converter configurations and checks them against an arithmetic decimal model.
module tb_bin2bcd_seq_ctrl;
  logic       clk, rst_n;
  logic       st0, st1, st2;
  logic [7:0] bin;
  logic       bs0, bs1, bs2, dn0, dn1, dn2, ov0, ov1, ov2;
  logic [11:0] b0;
  logic [7:0]  b1, b2;
  int checks = 0, passed = 0;

  bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) u0 (.clk(clk), .rst_n(rst_n), .start(st0), .bin_in(bin),
    .busy(bs0), .done(dn0), .bcd_out(b0), .overflow(ov0));
  bin2bcd_seq_ctrl #(.WIDTH(4), .DIGITS(2)) u1 (.clk(clk), .rst_n(rst_n), .start(st1), .bin_in(bin[3:0]),
    .busy(bs1), .done(dn1), .bcd_out(b1), .overflow(ov1));
  bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(2)) u2 (.clk(clk), .rst_n(rst_n), .start(st2), .bin_in(bin),
    .busy(bs2), .done(dn2), .bcd_out(b2), .overflow(ov2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int w);
    return (w == 1) ? 4 : 8;
  endfunction
  function automatic int digs(input int w);
    return (w == 0) ? 3 : 2;
  endfunction
  function automatic logic [11:0] ref_bcd(input int v, input int d);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < d; k++) begin
      r[4*k+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic logic ref_ovf(input int v, input int d);
    int p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return v >= p;
  endfunction
  function automatic logic [11:0] bcd_of(input int w);
    return (w == 0) ? b0 : (w == 1) ? {4'h0, b1} : {4'h0, b2};
  endfunction
  function automatic logic dn_of(input int w);
    return (w == 0) ? dn0 : (w == 1) ? dn1 : dn2;
  endfunction
  function automatic logic bs_of(input int w);
    return (w == 0) ? bs0 : (w == 1) ? bs1 : bs2;
  endfunction
  function automatic logic ov_of(input int w);
    return (w == 0) ? ov0 : (w == 1) ? ov1 : ov2;
  endfunction

  task automatic set_start(input int w, input logic x);
    if (w == 0) st0 = x;
    else if (w == 1) st1 = x;
    else st2 = x;
  endtask

  // pulse start for one edge, then count edges until done (bounded) and busy cycles seen on the way
  task automatic conv(input int w, input int v, output logic [11:0] b, output logic o,
                      output int lat, output int bc);
    @(negedge clk);
    bin = 8'(v);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    lat = 1;
    bc = 0;
    while (!dn_of(w) && lat < 40) begin
      if (bs_of(w)) bc++;
      @(negedge clk);
      lat++;
    end
    b = bcd_of(w);
    o = ov_of(w);
  endtask

  task automatic test_reset;
    logic [11:0] outs [3];
    rst_n = 1'b0;
    st0 = 0; st1 = 0; st2 = 0; bin = '0;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      outs[w] = {bs_of(w), dn_of(w), ov_of(w), 9'd0} | bcd_of(w);
      checks++;
      if (outs[w] !== 12'h000) $display("FAIL reset_outputs dut%0d got=%h want=000", w, outs[w]);
      else passed++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed;
    int tw [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2};
    int tv [10] = '{11, 255, 0, 11, 3, 14, 200, 99, 100, 199};
    logic [11:0] b, eb;
    logic o, eo;
    int lat, bc;
    for (int i = 0; i < 10; i++) begin
      conv(tw[i], tv[i], b, o, lat, bc);
      eb = ref_bcd(tv[i], digs(tw[i]));
      eo = ref_ovf(tv[i], digs(tw[i]));
      checks++;
      if (b !== eb) $display("FAIL fixed_bcd dut%0d in=%0d got=%h want=%h", tw[i], tv[i], b, eb);
      else passed++;
      checks++;
      if (o !== eo) $display("FAIL fixed_ovf dut%0d in=%0d got=%b want=%b", tw[i], tv[i], o, eo);
      else passed++;
      checks++;
      if (lat != wid(tw[i]) + 1) $display("FAIL fixed_latency dut%0d got=%0d want=%0d", tw[i], lat, wid(tw[i]) + 1);
      else passed++;
      checks++;
      if (bc != wid(tw[i])) $display("FAIL fixed_busy_cycles dut%0d got=%0d want=%0d", tw[i], bc, wid(tw[i]));
      else passed++;
      @(negedge clk);
      checks++;
      if (dn_of(tw[i]) !== 1'b0) $display("FAIL done_one_cycle dut%0d got=%b want=0", tw[i], dn_of(tw[i]));
      else passed++;
    end
  endtask

  task automatic test_random;
    logic [11:0] b, eb;
    logic o, eo;
    int lat, bc, w, v;
    for (int i = 0; i < 24; i++) begin
      w = int'($urandom_range(0, 2));
      v = int'($urandom_range(0, (1 << wid(w)) - 1));
      conv(w, v, b, o, lat, bc);
      eb = ref_bcd(v, digs(w));
      eo = ref_ovf(v, digs(w));
      checks++;
      if (b !== eb || o !== eo || lat != wid(w) + 1)
        $display("FAIL random_conv dut%0d in=%0d got=%h/%b/%0d want=%h/%b/%0d", w, v, b, o, lat, eb, eo, wid(w) + 1);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int n, lat;
    @(negedge clk);
    bin = 8'd37; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (2) @(negedge clk);
    bin = 8'd200; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0; bin = 8'd0;
    n = 0;
    while (!dn0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b0 !== 12'h037 || dn0 !== 1'b1) $display("FAIL ignore_start_busy got=%h done=%b want=037 done=1", b0, dn0);
    else passed++;
    bin = 8'd128; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0; bin = 8'd0;
    checks++;
    if ({dn0, bs0} !== 2'b01) $display("FAIL accept_in_done done_busy got=%b%b want=01", dn0, bs0);
    else passed++;
    checks++;
    if (b0 !== 12'h037) $display("FAIL hold_result got=%h want=037", b0);
    else passed++;
    lat = 1;
    while (!dn0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (b0 !== 12'h128 || lat != 9) $display("FAIL back_to_back got=%h lat=%0d want=128 lat=9", b0, lat);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [11:0] b;
    logic o;
    int lat, bc;
    @(negedge clk);
    bin = 8'd255; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bs0, dn0, ov0, b0} !== 15'd0) $display("FAIL async_reset got busy=%b done=%b ovf=%b bcd=%h want all 0", bs0, dn0, ov0, b0);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (dn0 !== 1'b0) $display("FAIL no_done_after_abort got=%b want=0", dn0);
    else passed++;
    rst_n = 1'b1;
    conv(0, 42, b, o, lat, bc);
    checks++;
    if (b !== 12'h042 || o !== 1'b0 || lat != 9) $display("FAIL after_reset got=%h/%b/%0d want=042/0/9", b, o, lat);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
- Sequential binary-to-BCD converter with a start/done handshake.
- Sequences a shift-and-add-3 (double-dabble) datapath over WIDTH clock cycles instead of building a wide combinational converter.
- Generalises our 4-bit, two-digit converter to parameterised widths.
- Feeds display/readout logic that needs multi-digit BCD from counters and sensor values.

Parameters:
- WIDTH, 8, binary input width in bits (>=2).
- DIGITS, 3, number of BCD output digits; bcd_out is 4*DIGITS bits wide.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE or DONE.
- bin_in  input  WIDTH  unsigned binary operand; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse; bcd_out and overflow are valid.
- bcd_out  output  4*DIGITS  result; digit 0 (units) is in [3:0], digit k is in [4k+3:4k].
- overflow  output  1  value did not fit in DIGITS digits; valid with done.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0; internal shift register and counter cleared. Deassertion takes effect at the next clk edge.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE: start=1 at edge E0 → load operand reg=bin_in, BCD accumulator=0, ovf_acc=0, cnt=WIDTH, go to SHIFT. start=0 → stay.
- SHIFT, one edge per bit:
  - For each digit, if digit>=5 then add 3 (4-bit, no carry out).
  - Then shift {accumulator, operand} left by 1.
  - If the bit shifted out of the top digit is 1, set ovf_acc.
  - Decrement cnt; when cnt reaches 0 on this edge, go to DONE.
- Entering DONE (edge E_WIDTH): bcd_out <= corrected/shifted accumulator, overflow <= ovf_acc, done <= 1.
- DONE lasts exactly one cycle:
  - start=1 → accept a new operand exactly as in IDLE (back-to-back; throughput one conversion per WIDTH+1 cycles).
  - Otherwise go to IDLE.
  - done deasserts on the next edge in both cases.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after the start-accepting edge counting E0.
- busy=1 from E0 through E_WIDTH-1, and 0 in IDLE and DONE.
- start while busy: ignored; bin_in changes while busy: ignored (operand already captured).
- bcd_out/overflow hold their last values from DONE until the next completion. They never show intermediate values.
- Overflow: with insufficient DIGITS, bcd_out = value mod 10^DIGITS and overflow=1. With sufficient DIGITS, overflow is always 0.
- Reset mid-conversion: conversion aborted; outputs cleared immediately (asynchronously); no done pulse.
- Operand 0: normal WIDTH-cycle conversion; result 0, done pulses.

Test Plan:
- WIDTH=8, DIGITS=3; bin_in=11 with start pulse at E0 → busy high for 8 cycles, done one cycle after E8, bcd_out=12'h011, overflow=0.
- WIDTH=8, DIGITS=3; bin_in=255 → bcd_out=12'h255. Then bin_in=0 → bcd_out=12'h000. done is exactly one cycle each time.
- WIDTH=4, DIGITS=2; sequence bin_in=4'b1011, 4'b0011, 4'b1110 → bcd_out=8'h11, 8'h03, 8'h14, each 5 edges after its start.
- WIDTH=8, DIGITS=2; bin_in=200 → bcd_out=8'h00, overflow=1. Then bin_in=99 → bcd_out=8'h99, overflow=0.
- Start at E0 with 37, start again at E3 with 200 → 200 ignored; result 12'h037. Start held high during DONE with 128 → accepted immediately; next result 12'h128.
- Assert rst_n=0 at E4 of a conversion of 255 → busy/done/bcd_out drop to 0 without waiting for a clock edge; no done pulse. After release, start with 42 → 12'h042.
